mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles in BUSY without mem_ack before the access is abandoned (1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces every register to its reset value immediately.
REQ-004 in_valid  in  1  instruction present from EX/M register.
REQ-005 is_load, is_store, is_byte, reg_write  in  1 each  op class, byte (vs word) size, destination write enable.
REQ-006 addr  in  32  effective address; alu_result  in  32  ALU value; store_data  in  32  store operand; rgD_index_in  in  5  destination register.
REQ-007 stall  out  1  combinational; upstream holds in_* while 1.
REQ-008 mem_req, mem_we  out  1 each; mem_addr  out  32 (word-aligned, [1:0]=0); mem_be  out  4; mem_wdata  out  32.
REQ-009 mem_ack  in  1; mem_rdata  in  32  valid when mem_ack=1.
REQ-010 wb_valid, wb_reg_write, wb_sel_mem  out  1 each; mem_data_out, data_out  out  32; rgD_index_out  out  5; these feed the M/WB register.
REQ-011 fault  out  1  one-cycle pulse; fault_addr  out  32  address of last faulting access.

Function
REQ-012 States: IDLE, BUSY; all M/WB-side outputs are registered.
REQ-013 IDLE, in_valid=0: wb_valid<=0, other wb outputs hold, stall=0.
REQ-014 IDLE, in_valid=1, neither load nor store: next cycle wb_valid=1, wb_reg_write=reg_write, wb_sel_mem=0, data_out=alu_result, rgD_index_out=rgD_index_in; stall=0; one-cycle latency.
REQ-015 IDLE, aligned memory op: stall=1 that cycle; addr, store_data, size, load/store, rgD_index_in, reg_write, alu_result captured; state->BUSY; wb_valid<=0.
REQ-016 Aligned: byte ops always; word ops require addr[1:0]=0; loads and stores both.
REQ-017 BUSY: mem_req=1, mem_we=captured is_store, mem_addr={addr[31:2],2'b00}, held stable until ack; mem_req=0 in IDLE.
REQ-018 Word store: mem_be=4'hF, mem_wdata=store_data; byte store: mem_be one-hot at bit addr[1:0], mem_wdata=store_data[7:0] replicated to all four lanes; loads: mem_be=4'hF, mem_wdata=0.
REQ-019 BUSY, mem_ack=0: stall=1, wait counter increments.
REQ-020 BUSY, mem_ack=1: stall=0 (upstream advances same edge); next cycle wb_valid=1, wb_sel_mem=is_load, wb_reg_write=reg_write&is_load, data_out=captured alu_result, rgD_index_out=captured index; state->IDLE; counter cleared.
REQ-021 Load data: word -> mem_data_out=mem_rdata; byte -> zero-extended mem_rdata[8*addr[1:0]+7 : 8*addr[1:0]] (little-endian). Store completion leaves mem_data_out unchanged.
REQ-022 Timeout: BUSY with counter reaching TIMEOUT and mem_ack=0 -> mem_req drops next cycle, fault pulses 1 cycle, fault_addr=addr, wb_valid=1 with wb_reg_write=0, stall=0 that cycle, state->IDLE; ack on the timeout cycle takes precedence (normal completion).
REQ-023 Misaligned word op in IDLE: no memory request, stall=0, next cycle fault=1, fault_addr=addr, wb_valid=1, wb_reg_write=0.
REQ-024 in_* changes while stall=1 are ignored; captured values govern the access.
REQ-025 Back-to-back memory ops: the following op is accepted in the IDLE cycle after completion; no bubble beyond that IDLE cycle.

Reset
REQ-026 reset=0 at any time, including mid-access: state=IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, stall follows IDLE rules, wb_valid=0, wb_reg_write=0, wb_sel_mem=0, mem_data_out=0, data_out=0, rgD_index_out=0, fault=0, fault_addr=0, counter=0; an outstanding access is abandoned and a late mem_ack is ignored.

Verification
REQ-027 ALU op alu_result=0x12345678, rgD=5, reg_write=1 -> next cycle wb_valid=1, data_out=0x12345678, rgD_index_out=5, wb_sel_mem=0, stall never 1.
REQ-028 Word load addr=0x100, ack after 3 cycles with rdata=0xDEADBEEF -> mem_addr=0x100, stall=1 for 4 cycles, then wb_valid=1, mem_data_out=0xDEADBEEF, wb_reg_write=1.
REQ-029 Byte load addr=0x103, rdata=0xAABBCCDD -> mem_data_out=0x000000AA; byte store addr=0x101, store_data=0x55 -> mem_be=4'b0010, mem_wdata=0x55555555, mem_we=1, wb_reg_write=0.
REQ-030 Word load addr=0x102 -> no mem_req, fault pulse, fault_addr=0x102, wb_valid=1, wb_reg_write=0.
REQ-031 TIMEOUT=4, no ack -> mem_req high exactly through the timeout cycle, then fault pulse, wb_reg_write=0, state IDLE; ack in final cycle -> normal completion, no fault.
REQ-032 reset=0 asserted during BUSY, then ack arrives -> all outputs zero immediately, ack ignored, next load after reset behaves as REQ-028.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory stage access unit: turns EX/M load/store requests into a single
// outstanding memory handshake and presents the results to the M/WB register.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_byte,
    input  logic        reg_write,
    input  logic [31:0] addr,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rgD_index_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic        wb_sel_mem,
    output logic [31:0] mem_data_out,
    output logic [31:0] data_out,
    output logic [4:0]  rgD_index_out,
    output logic        fault,
    output logic [31:0] fault_addr
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_next;

    logic [7:0]  wait_cnt;
    logic        timeout_hit;

    logic        accept, misalign, alu_pass, ack_done, timed_out;

    logic [31:0] c_addr;
    logic [31:0] c_alu;
    logic        c_load;
    logic        c_byte;
    logic        c_reg_write;
    logic [4:0]  c_rd;

    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  rd_byte;

    // The access is abandoned in the TIMEOUT-th BUSY cycle without an ack.
    assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        accept     = 1'b0;
        misalign   = 1'b0;
        alu_pass   = 1'b0;
        ack_done   = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_load || is_store) begin
                        if (is_byte || (addr[1:0] == 2'b00)) begin
                            accept     = 1'b1;
                            stall      = 1'b1;
                            state_next = BUSY;
                        end else begin
                            misalign = 1'b1;
                        end
                    end else begin
                        alu_pass = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    ack_done   = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte stores put the byte on every lane and enable only the addressed one.
    always_comb begin
        be_next    = 4'hF;
        wdata_next = 32'h0;
        if (is_store) begin
            if (is_byte) begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{store_data[7:0]}};
            end else begin
                wdata_next = store_data;
            end
        end
    end

    assign rd_byte = mem_rdata[{c_addr[1:0], 3'b000} +: 8];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt      <= '0;
            c_addr        <= '0;
            c_alu         <= '0;
            c_load        <= 1'b0;
            c_byte        <= 1'b0;
            c_reg_write   <= 1'b0;
            c_rd          <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= '0;
            mem_wdata     <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_sel_mem    <= 1'b0;
            mem_data_out  <= '0;
            data_out      <= '0;
            rgD_index_out <= '0;
            fault         <= 1'b0;
            fault_addr    <= '0;
        end else begin
            wb_valid <= alu_pass | misalign | ack_done | timed_out;
            fault    <= misalign | timed_out;

            if (accept) begin
                wait_cnt    <= '0;
                c_addr      <= addr;
                c_alu       <= alu_result;
                c_load      <= is_load;
                c_byte      <= is_byte;
                c_reg_write <= reg_write;
                c_rd        <= rgD_index_in;
                mem_req     <= 1'b1;
                mem_we      <= is_store;
                mem_addr    <= {addr[31:2], 2'b00};
                mem_be      <= be_next;
                mem_wdata   <= wdata_next;
            end

            if (state == BUSY && !mem_ack && !timeout_hit)
                wait_cnt <= wait_cnt + 8'd1;

            if (ack_done || timed_out) begin
                wait_cnt <= '0;
                mem_req  <= 1'b0;
                mem_we   <= 1'b0;
            end

            if (alu_pass || misalign) begin
                wb_reg_write  <= alu_pass & reg_write;
                wb_sel_mem    <= 1'b0;
                data_out      <= alu_result;
                rgD_index_out <= rgD_index_in;
            end

            if (misalign) fault_addr <= addr;

            if (ack_done) begin
                wb_reg_write  <= c_reg_write & c_load;
                wb_sel_mem    <= c_load;
                data_out      <= c_alu;
                rgD_index_out <= c_rd;
                if (c_load)
                    mem_data_out <= c_byte ? {24'h0, rd_byte} : mem_rdata;
            end

            if (timed_out) begin
                wb_reg_write  <= 1'b0;
                wb_sel_mem    <= 1'b0;
                data_out      <= c_alu;
                rgD_index_out <= c_rd;
                fault_addr    <= c_addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized operations predicted by a transaction-level reference model.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, is_load, is_store, is_byte, reg_write;
    logic [31:0] addr, alu_result, store_data;
    logic [4:0]  rgD_index_in;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid, wb_reg_write, wb_sel_mem;
    logic [31:0] mem_data_out, data_out;
    logic [4:0]  rgD_index_out;
    logic        fault;
    logic [31:0] fault_addr;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_mdo;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .is_load(is_load), .is_store(is_store),
        .is_byte(is_byte), .reg_write(reg_write),
        .addr(addr), .alu_result(alu_result), .store_data(store_data),
        .rgD_index_in(rgD_index_in),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_sel_mem(wb_sel_mem),
        .mem_data_out(mem_data_out), .data_out(data_out),
        .rgD_index_out(rgD_index_out),
        .fault(fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got running, want finished)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic scramble_inputs();
        is_load      = 1'($urandom);
        is_store     = 1'($urandom);
        is_byte      = 1'($urandom);
        reg_write    = 1'($urandom);
        addr         = $urandom;
        alu_result   = $urandom;
        store_data   = $urandom;
        rgD_index_in = 5'($urandom);
    endtask

    // One instruction from presentation to its M/WB result; ack arrives on
    // BUSY cycle ack_delay+1, which is too late once that exceeds TO.
    task automatic run_op(input bit ld, input bit st, input bit byt, input bit rw,
                          input logic [31:0] a, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [4:0] rd,
                          input int ack_delay, input logic [31:0] rdata);
        bit          ok_align;
        bit          acked;
        int          stalls;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        ok_align = byt || (a[1:0] == 2'b00);
        in_valid = 1'b1; is_load = ld; is_store = st; is_byte = byt; reg_write = rw;
        addr = a; alu_result = alu; store_data = sd; rgD_index_in = rd;
        @(negedge clk);
        if (!(ld || st)) begin
            check("alu_stall", stall, 0);
            check("alu_req", mem_req, 0);
            @(posedge clk); #1;
            check("alu_wb_valid", wb_valid, 1);
            check("alu_wb_rw", wb_reg_write, rw);
            check("alu_sel_mem", wb_sel_mem, 0);
            check("alu_data", data_out, alu);
            check("alu_rd", rgD_index_out, rd);
            check("alu_fault", fault, 0);
            return;
        end
        if (!ok_align) begin
            check("mis_stall", stall, 0);
            check("mis_req", mem_req, 0);
            @(posedge clk); #1;
            check("mis_req_after", mem_req, 0);
            check("mis_fault", fault, 1);
            check("mis_fault_addr", fault_addr, a);
            check("mis_wb_valid", wb_valid, 1);
            check("mis_wb_rw", wb_reg_write, 0);
            return;
        end
        check("acc_stall", stall, 1);
        stalls = 1;
        @(posedge clk); #1;
        check("acc_wb_valid", wb_valid, 0);
        check("acc_fault", fault, 0);
        if (st && byt) begin
            e_be = 4'(1 << a[1:0]);
            e_wd = {4{sd[7:0]}};
        end else begin
            e_be = 4'hF;
            e_wd = st ? sd : 32'h0;
        end
        acked = 1'b0;
        for (int n = 1; n <= TO; n++) begin
            scramble_inputs();
            mem_ack   = (n == ack_delay + 1);
            mem_rdata = mem_ack ? rdata : $urandom;
            @(negedge clk);
            check("busy_req", mem_req, 1);
            check("busy_we", mem_we, st);
            check("busy_addr", mem_addr, {a[31:2], 2'b00});
            check("busy_be", mem_be, e_be);
            check("busy_wdata", mem_wdata, e_wd);
            check("busy_stall", stall, (mem_ack || n == TO) ? 0 : 1);
            if (stall) stalls++;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (n == ack_delay + 1) begin
                acked = 1'b1;
                break;
            end
        end
        check("stall_cycles", stalls, acked ? ack_delay + 1 : TO);
        check("done_req", mem_req, 0);
        check("done_wb_valid", wb_valid, 1);
        if (acked) begin
            if (ld) exp_mdo = byt ? ((rdata >> (8 * a[1:0])) & 32'hFF) : rdata;
            check("done_fault", fault, 0);
            check("done_sel_mem", wb_sel_mem, ld);
            check("done_wb_rw", wb_reg_write, rw & ld);
            check("done_data", data_out, alu);
            check("done_rd", rgD_index_out, rd);
            check("done_mdo", mem_data_out, exp_mdo);
        end else begin
            check("to_fault", fault, 1);
            check("to_fault_addr", fault_addr, a);
            check("to_wb_rw", wb_reg_write, 0);
        end
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        scramble_inputs();
        @(negedge clk);
        check("idle_stall", stall, 0);
        @(posedge clk); #1;
        check("idle_wb_valid", wb_valid, 0);
        check("idle_fault", fault, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, mem_req, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_be"}, mem_be, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_wb_valid"}, wb_valid, 0);
        check({tag, "_wb_rw"}, wb_reg_write, 0);
        check({tag, "_sel_mem"}, wb_sel_mem, 0);
        check({tag, "_mdo"}, mem_data_out, 0);
        check({tag, "_data"}, data_out, 0);
        check({tag, "_rd"}, rgD_index_out, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_fault_addr"}, fault_addr, 0);
    endtask

    initial begin
        bit          ld, st, byt;
        logic [31:0] a;
        reset = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        in_valid = 1'b0; scramble_inputs();
        exp_mdo = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        check("rst_stall", stall, 0);
        reset = 1'b1;

        // Directed scenarios.
        run_op(0, 0, 0, 1, 32'h0, 32'h12345678, 32'h0, 5'd5, 0, 32'h0);
        run_op(1, 0, 0, 1, 32'h100, 32'h0, 32'h0, 5'd7, 3, 32'hDEADBEEF);
        run_op(1, 0, 1, 1, 32'h103, 32'h0, 32'h0, 5'd8, 0, 32'hAABBCCDD);
        run_op(0, 1, 1, 1, 32'h101, 32'h0, 32'h55, 5'd9, 1, 32'h0);
        run_op(1, 0, 0, 1, 32'h102, 32'h0, 32'h0, 5'd3, 0, 32'h0);
        run_op(1, 0, 0, 1, 32'h200, 32'h0, 32'h0, 5'd4, 10, 32'h0);
        run_op(1, 0, 0, 1, 32'h204, 32'h0, 32'h0, 5'd4, TO - 1, 32'hCAFEF00D);
        idle_cycle();

        // Reset while BUSY; the later ack must be ignored.
        in_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; is_byte = 1'b0;
        reg_write = 1'b1; addr = 32'h300; rgD_index_in = 5'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("mid_rst");
        mem_ack = 1'b1; mem_rdata = 32'h87654321;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("late_ack_valid", wb_valid, 0);
        check("late_ack_req", mem_req, 0);
        check("late_ack_mdo", mem_data_out, 0);
        exp_mdo = 32'h0;
        run_op(1, 0, 0, 1, 32'h100, 32'h0, 32'h0, 5'd7, 3, 32'hDEADBEEF);

        // Randomized operations, back to back with occasional bubbles.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) == 0) idle_cycle();
            case ($urandom_range(0, 2))
                0:       begin ld = 0; st = 0; end
                1:       begin ld = 1; st = 0; end
                default: begin ld = 0; st = 1; end
            endcase
            byt = 1'($urandom);
            a   = $urandom;
            if (!byt && $urandom_range(0, 9) < 7) a[1:0] = 2'b00;
            run_op(ld, st, byt, 1'($urandom), a, $urandom, $urandom,
                   5'($urandom), $urandom_range(0, TO + 1), $urandom);
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
